// File: rtl/miriscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_lsu
//  Brief    : Load/store unit. Issues one word-aligned data-memory request
//             per load/store, stalls one cycle for the synchronous-read
//             memory, and returns sign/zero-extended load data.
//  Revision : 1.0 - initial release
// ============================================================================
module miriscv_lsu (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        r_we;
    logic        r_rst_q;

    logic        w_block;
    logic        w_legal;
    logic        w_take;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // Outputs are forced quiet while in reset and for the cycle following it.
    assign w_block = rst_i | r_rst_q;

    // Access legality: alignment per size, and size codes valid per direction.
    always_comb begin
        w_legal = 1'b0;
        case (lsu_size_i)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~lsu_addr_i[0];
            3'b010:  w_legal = (lsu_addr_i[1:0] == 2'b00);
            3'b100:  w_legal = ~lsu_we_i;
            3'b101:  w_legal = ~lsu_we_i & ~lsu_addr_i[0];
            default: w_legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated write data; loads reuse the same enables.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << lsu_addr_i[1:0];
                w_wdata = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                w_wdata = {2{lsu_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = lsu_data_i;
            end
        endcase
    end

    // Extract and extend the load result from the returned word.
    assign w_byte = data_rdata_i[{r_off, 3'b000} +: 8];
    assign w_half = data_rdata_i[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        case (r_size)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = data_rdata_i;
        endcase
    end

    assign w_take = (r_state == S_IDLE) && lsu_req_i && w_legal && !w_block;

    // Next-state and output decode; everything defaults to idle/zero.
    always_comb begin
        w_state_nxt     = r_state;
        lsu_data_o      = 32'h0;
        lsu_stall_req_o = 1'b0;
        lsu_err_o       = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0000;
        data_addr_o     = 32'h0;
        data_wdata_o    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i && !w_block) begin
                    if (w_legal) begin
                        data_req_o      = 1'b1;
                        data_we_o       = lsu_we_i;
                        data_be_o       = w_be;
                        data_addr_o     = {lsu_addr_i[31:2], 2'b00};
                        data_wdata_o    = w_wdata;
                        lsu_stall_req_o = 1'b1;
                        w_state_nxt     = S_DONE;
                    end else begin
                        lsu_err_o = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (!w_block && !r_we) begin
                    lsu_data_o = w_ext;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus capture of size/offset/direction for the response cycle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_size  <= 3'b000;
            r_off   <= 2'b00;
            r_we    <= 1'b0;
            r_rst_q <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_rst_q <= 1'b0;
            if (w_take) begin
                r_size <= lsu_size_i;
                r_off  <= lsu_addr_i[1:0];
                r_we   <= lsu_we_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_miriscv_lsu
//  Brief    : Self-checking bench for miriscv_lsu with a word memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_miriscv_lsu;

    logic        clk;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    miriscv_lsu u_dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_rdata_i    (data_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read, byte-writable memory: 64 words.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (data_req_o) begin
            if (data_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_be_o[b]) mem[data_addr_o[7:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
                end
            end
            data_rdata_i <= mem[data_addr_o[7:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        lsu_req_i  = req;
        lsu_we_i   = we;
        lsu_size_i = sz;
        lsu_addr_i = a;
        lsu_data_i = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic err, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.we = we; v.size = sz; v.addr = a; v.data = d;
        v.err = err; v.be = be; v.wdata = wd; v.ldata = ld;
        vecs.push_back(v);
    endtask

    initial begin
        //   we    size    addr    data          err   be       wdata          ldata
        add(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
        add(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        add(1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 4'b1111, 32'h0,        32'hA5ADBEEF);
        add(1'b1, 3'b010, 32'h20, 32'h80FF7F01, 1'b0, 4'b1111, 32'h80FF7F01, 32'h0);
        add(1'b0, 3'b000, 32'h21, 32'h0,        1'b0, 4'b0010, 32'h0,        32'h0000007F);
        add(1'b0, 3'b000, 32'h22, 32'h0,        1'b0, 4'b0100, 32'h0,        32'hFFFFFFFF);
        add(1'b0, 3'b100, 32'h23, 32'h0,        1'b0, 4'b1000, 32'h0,        32'h00000080);
        add(1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 4'b1100, 32'h0,        32'hFFFF80FF);
        add(1'b0, 3'b101, 32'h20, 32'h0,        1'b0, 4'b0011, 32'h0,        32'h00007F01);
        add(1'b1, 3'b010, 32'h04, 32'h11223344, 1'b0, 4'b1111, 32'h11223344, 32'h0);
        add(1'b0, 3'b010, 32'h12, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
        add(1'b1, 3'b001, 32'h05, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h0,        32'h0);
        add(1'b0, 3'b011, 32'h20, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0);
        add(1'b1, 3'b100, 32'h04, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h0,        32'h0);
        add(1'b0, 3'b010, 32'h04, 32'h0,        1'b0, 4'b1111, 32'h0,        32'h11223344);
        add(1'b1, 3'b001, 32'h16, 32'h1234CAFE, 1'b0, 4'b1100, 32'hCAFECAFE, 32'h0);
        add(1'b0, 3'b101, 32'h16, 32'h0,        1'b0, 4'b1100, 32'h0,        32'h0000CAFE);

        // Reset: outputs quiet during reset and the cycle after, even with a request pending.
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_req",   {31'h0, data_req_o},      32'h0);
        chk("rst_stall", {31'h0, lsu_stall_req_o}, 32'h0);
        chk("rst_err",   {31'h0, lsu_err_o},       32'h0);
        chk("rst_addr",  data_addr_o,              32'h0);
        next_cycle();
        rst_i = 1'b0;
        @(negedge clk);
        chk("postrst_req",   {31'h0, data_req_o},      32'h0);
        chk("postrst_stall", {31'h0, lsu_stall_req_o}, 32'h0);
        chk("postrst_be",    {28'h0, data_be_o},       32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("idle_noreq", {31'h0, data_req_o}, 32'h0);
        next_cycle();

        // Table-driven single accesses.
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(1'b1, v.we, v.size, v.addr, v.data);
            @(negedge clk);
            chk($sformatf("v%0d_err", i),   {31'h0, lsu_err_o},       {31'h0, v.err});
            chk($sformatf("v%0d_req", i),   {31'h0, data_req_o},      {31'h0, ~v.err});
            chk($sformatf("v%0d_stall", i), {31'h0, lsu_stall_req_o}, {31'h0, ~v.err});
            if (!v.err) begin
                chk($sformatf("v%0d_we", i),   {31'h0, data_we_o}, {31'h0, v.we});
                chk($sformatf("v%0d_be", i),   {28'h0, data_be_o}, {28'h0, v.be});
                chk($sformatf("v%0d_addr", i), data_addr_o,        {v.addr[31:2], 2'b00});
                if (v.we) chk($sformatf("v%0d_wdata", i), data_wdata_o, v.wdata);
            end
            next_cycle();
            drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_done_stall", i), {31'h0, lsu_stall_req_o}, 32'h0);
            chk($sformatf("v%0d_done_req", i),   {31'h0, data_req_o},      32'h0);
            chk($sformatf("v%0d_done_err", i),   {31'h0, lsu_err_o},       32'h0);
            if (!v.err) chk($sformatf("v%0d_ldata", i), lsu_data_o, v.ldata);
            next_cycle();
        end

        // Request held high: one access every two cycles.
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d_req", c),   {31'h0, data_req_o},      {31'h0, (c % 2) == 0});
            chk($sformatf("b2b%0d_stall", c), {31'h0, lsu_stall_req_o}, {31'h0, (c % 2) == 0});
            if ((c % 2) == 1) chk($sformatf("b2b%0d_data", c), lsu_data_o, 32'hA5ADBEEF);
            next_cycle();
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();

        // Reset asserted in the DONE cycle of a load, then a normal load.
        drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        chk("rd_issue_req", {31'h0, data_req_o}, 32'h1);
        next_cycle();
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("rd_done_data",  lsu_data_o,               32'h0);
        chk("rd_done_stall", {31'h0, lsu_stall_req_o}, 32'h0);
        next_cycle();
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        chk("rd_after_req",   {31'h0, data_req_o},      32'h0);
        chk("rd_after_stall", {31'h0, lsu_stall_req_o}, 32'h0);
        chk("rd_after_data",  lsu_data_o,               32'h0);
        next_cycle();
        @(negedge clk);
        chk("rd_lw_req",   {31'h0, data_req_o},      32'h1);
        chk("rd_lw_stall", {31'h0, lsu_stall_req_o}, 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("rd_lw_data", lsu_data_o, 32'hA5ADBEEF);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
